// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one full-adder cell stepped LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_full;
  logic             carry;
  logic [CW-1:0]    count;
  logic             cell_s;
  logic             cell_co;
  logic             last_bit;
  logic             accept;

  assign cell_s   = a_sr[0] ^ b_sr[0] ^ carry;
  assign cell_co  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (count == CW'(WIDTH - 1));

  // Value sum_sr takes after the current bit's s enters at the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_full = cell_s;
    end else begin : g_wn
      assign sum_full = {cell_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      count  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_full;
      carry  <= cell_co;
      count  <= count + CW'(1);
      if (last_bit) begin
        sum  <= sum_full;
        cout <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
        // carry register holds the carry into the MSB on the last bit.
        ovf  <= carry ^ cell_co;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  // Drives one add from IDLE and waits (bounded) for done; stops at the done cycle.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit scramble, output int lat, output int busy_cnt, output bit ok);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b cout=%b sum=%h, want 1 0 0 0 00",
               ready, busy, done, cout, sum);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic;
    int lat, bc; bit ok;
    do_add(8'h35, 8'h4A, 1'b0, 1'b0, lat, bc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: no done within %0d cycles", lat); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL basic_busy: got %0d cycles want 8", bc); end
    checks++;
    if ({cout, sum} !== 9'h07F) begin
      errors++; $display("FAIL basic_sum: got cout=%b sum=%h want 0 7f", cout, sum);
    end
    @(negedge clk);
    checks++;
    if ({done, ready, busy} !== 3'b010) begin
      errors++; $display("FAIL basic_after: done=%b ready=%b busy=%b want 0 1 0", done, ready, busy);
    end
  endtask

  task automatic test_carry;
    int lat, bc; bit ok;
    do_add(8'hFF, 8'h01, 1'b1, 1'b0, lat, bc, ok);
    checks++;
    if (!ok || {cout, sum} !== 9'h101) begin
      errors++; $display("FAIL carry_sum: done=%b cout=%b sum=%h want 1 1 01", ok, cout, sum);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf: got %b want 0", ovf); end
    do_add(8'h7F, 8'h01, 1'b0, 1'b0, lat, bc, ok);
    checks++;
    if (!ok || {cout, sum, ovf} !== {1'b0, 8'h80, 1'b1}) begin
      errors++; $display("FAIL ovf_case: done=%b cout=%b sum=%h ovf=%b want 1 0 80 1", ok, cout, sum, ovf);
    end
`endif
  endtask

  task automatic test_random;
    int lat, bc; bit ok;
    logic [W-1:0] av, bv; logic cv;
    logic [W:0] exp;
    for (int i = 0; i < 20; i++) begin
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      exp = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
      do_add(av, bv, cv, 1'b1, lat, bc, ok);
      checks++;
      if (!ok || lat !== 9 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL random_%0d: %h+%h+%b done=%b lat=%0d got %h want %h",
                 i, av, bv, cv, ok, lat, {cout, sum}, exp);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf !== ((av[W-1] == bv[W-1]) && (exp[W-1] != av[W-1]))) begin
        errors++; $display("FAIL random_ovf_%0d: %h+%h+%b got %b", i, av, bv, cv, ovf);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    int done_t[$];
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) begin
        done_t.push_back(cyc);
        checks++;
        if ({cout, sum} !== 9'h030) begin
          errors++; $display("FAIL b2b_sum: cycle %0d got %h want 030", cyc, {cout, sum});
        end
      end
      // Only the IDLE-cycle operands are legal captures; anything else is noise.
      if (ready) begin a = 8'h10; b = 8'h20; cin = 1'b0; end
      else begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_t.size() < 3) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses want >=3", done_t.size());
    end else begin
      for (int k = 1; k < done_t.size(); k++) begin
        checks++;
        if (done_t[k] - done_t[k-1] !== 10) begin
          errors++; $display("FAIL b2b_period: got %0d want 10", done_t[k] - done_t[k-1]);
        end
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int lat, bc; bit ok; bit saw_done;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid: ready=%b busy=%b done=%b cout=%b sum=%h want 1 0 0 0 00",
               ready, busy, done, cout, sum);
    end
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL rst_mid_nodone: got done pulse want none"); end
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({ready, busy} !== 2'b10) begin
      errors++; $display("FAIL rst_start: ready=%b busy=%b want 1 0", ready, busy);
    end
    do_add(8'h01, 8'h02, 1'b0, 1'b0, lat, bc, ok);
    checks++;
    if (!ok || {cout, sum} !== 9'h003) begin
      errors++; $display("FAIL rst_follow: done=%b got %h want 003", ok, {cout, sum});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one 1-bit full-adder cell (s = a^b^cin, cout = majority) across WIDTH-bit operands, LSB first, one bit per clock.
- Provides start/ready/done handshake, operand/result shift registers, carry flop and bit counter.
- Lets the arithmetic library trade area for latency against the parallel ripple adders.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- cin  input  1  carry-in; captured on the accepted start
- ready  output  1  high only in IDLE
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result register
- cout  output  1  final carry-out register

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, all shift registers, carry flop and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clk edge -> load a_sr=a, b_sr=b, carry=cin, count=0, sum_sr=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN, each cycle:
  - Full-adder cell inputs: a_sr[0], b_sr[0], carry.
  - a_sr and b_sr shift right by 1, zero-filled.
  - sum_sr shifts right with the cell's s bit entering bit WIDTH-1.
  - carry <= cell cout; count <= count+1.
  - When count==WIDTH-1: the final bit is processed, sum <= completed sum_sr value, cout <= cell cout, go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, busy=0; next state IDLE unconditionally.
- Latency: start sampled at edge E0; done high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance. Throughput is one add per WIDTH+2 cycles.
- sum/cout hold the previous result throughout RUN. Both update only on the edge that enters DONE and hold until the next completion or rst.
- start while busy=1 or in DONE is ignored; no queueing.
- Operand inputs a, b, cin are don't-care except on the accepting edge.
- WIDTH=1: RUN lasts one cycle; done is high the 2nd cycle after start.
- Counter width is clog2(WIDTH+1) bits. No wrap occurs because the FSM leaves RUN at WIDTH-1.
- rst mid-operation (RUN or DONE): next cycle is IDLE with reset values. The partial result is discarded and no done pulse is issued.
- rst and start asserted together: rst wins and start is ignored.
- Result is the modular (a+b+cin) mod 2^WIDTH; the carry beyond bit WIDTH-1 appears on cout.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit, reset 0.
  - ovf is the signed two's-complement overflow: carry into the MSB XOR carry out of the MSB.
  - Captured on the same edge as sum/cout and held with them.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, rst held 2 cycles then released -> ready=1, busy=0, done=0, sum=0x00, cout=0.
- a=0x35, b=0x4A, cin=0, start 1 cycle -> busy for 8 cycles; done pulses once in cycle 9 after the start edge; sum=0x7F, cout=0; ready returns next cycle.
- a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1. With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- start held high continuously with a=0x10, b=0x20 -> start ignored during RUN/DONE. Back-to-back results 0x30 arrive every 10 cycles; the 2nd operand set is captured only in IDLE.
- During RUN, a/b changed every cycle to random values -> result still equals the values captured at acceptance.
- rst pulsed at the 4th RUN cycle of a=0xAA, b=0x55 -> no done pulse; sum/cout=0. A following add of 0x01+0x02 completes normally with sum=0x03.
